// File: rtl/ga_mask_generator.sv
// rtl/ga_mask_generator.sv - GA crossover/mutation mask generator; GA_MASK_SEED_LOAD_EN adds seed_load/seed reseed ports
module ga_mask_generator #(
  parameter int          Width = 32,
  parameter logic [31:0] Seed  = 32'hACE12468
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [7:0]       rate,
  input  logic             ack,
`ifdef GA_MASK_SEED_LOAD_EN
  input  logic             seed_load,
  input  logic [31:0]      seed,
`endif
  output logic             busy,
  output logic             valid,
  output logic [Width-1:0] crossover_mask,
  output logic [Width-1:0] daughter_mutation_mask,
  output logic [Width-1:0] son_mutation_mask
);

  localparam int              CntW    = $clog2(Width);
  localparam logic [CntW-1:0] LastBit = CntW'(Width - 1);
  localparam logic [31:0]     Taps    = 32'h80200003;

  typedef enum logic [1:0] {IDLE, BUILD, HOLD} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [31:0]      r_lfsr;
  logic [31:0]      w_lfsr_step;
  logic [31:0]      w_lfsr_nxt;
  logic [CntW-1:0]  r_cnt;
  logic [7:0]       r_rate;
  logic [Width-1:0] r_xmask;
  logic [Width-1:0] r_dmask;
  logic [Width-1:0] r_smask;
  logic             w_accept;

  // Galois step: shift right, fold the taps back in when the outgoing bit is set
  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ Taps) : (r_lfsr >> 1);

`ifdef GA_MASK_SEED_LOAD_EN
  // A zero seed would lock the LFSR, so it falls back to the reset seed
  assign w_lfsr_nxt = seed_load ? ((seed == 32'h0) ? Seed : seed) : w_lfsr_step;
`else
  assign w_lfsr_nxt = w_lfsr_step;
`endif

  assign w_accept = (r_state == IDLE) && req;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: req only counts in IDLE, ack only in HOLD
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (req) w_state_nxt = BUILD;
      BUILD:   if (r_cnt == LastBit) w_state_nxt = HOLD;
      HOLD:    if (ack) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // LFSR free-runs in every state; masks are filled one bit per BUILD cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr  <= Seed;
      r_cnt   <= '0;
      r_rate  <= 8'h00;
      r_xmask <= '0;
      r_dmask <= '0;
      r_smask <= '0;
    end else begin
      r_lfsr <= w_lfsr_nxt;
      if (w_accept) begin
        r_rate  <= rate;
        r_cnt   <= '0;
        r_xmask <= '0;
        r_dmask <= '0;
        r_smask <= '0;
      end else if (r_state == BUILD) begin
        r_xmask[r_cnt] <= r_lfsr[0];
        r_dmask[r_cnt] <= (r_lfsr[15:8] < r_rate);
        r_smask[r_cnt] <= (r_lfsr[23:16] < r_rate);
        r_cnt          <= r_cnt + 1'b1;
      end
    end
  end

  assign busy                   = (r_state == BUILD);
  assign valid                  = (r_state == HOLD);
  assign crossover_mask         = r_xmask;
  assign daughter_mutation_mask = r_dmask;
  assign son_mutation_mask      = r_smask;

endmodule

// File: tb/tb_ga_mask_generator.sv
// tb/tb_ga_mask_generator.sv - randomized self-checking bench for ga_mask_generator
module tb_ga_mask_generator;

  localparam logic [31:0] SEED = 32'hACE12468;
  localparam logic [31:0] POLY = 32'h80200003;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req8 = 1'b0, ack8 = 1'b0, req32 = 1'b0, ack32 = 1'b0;
  logic [7:0]  rate8 = 8'h00, rate32 = 8'h00;
  logic        busy8, valid8, busy32, valid32;
  logic [7:0]  xm8, dm8, sm8;
  logic [31:0] xm32, dm32, sm32;
  logic        seed_load = 1'b0;
  logic [31:0] seed = 32'h0;
  logic [31:0] m_lfsr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ga_mask_generator #(.Width(8), .Seed(SEED)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .rate(rate8), .ack(ack8),
`ifdef GA_MASK_SEED_LOAD_EN
    .seed_load(seed_load), .seed(seed),
`endif
    .busy(busy8), .valid(valid8), .crossover_mask(xm8),
    .daughter_mutation_mask(dm8), .son_mutation_mask(sm8)
  );

  ga_mask_generator #(.Width(32), .Seed(SEED)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .req(req32), .rate(rate32), .ack(ack32),
`ifdef GA_MASK_SEED_LOAD_EN
    .seed_load(seed_load), .seed(seed),
`endif
    .busy(busy32), .valid(valid32), .crossover_mask(xm32),
    .daughter_mutation_mask(dm32), .son_mutation_mask(sm32)
  );

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? POLY : 32'h0);
  endfunction

  // Reference LFSR: both DUTs share reset timing, so one sequence serves both
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else if (seed_load) m_lfsr <= (seed == 32'h0) ? SEED : seed;
    else m_lfsr <= lfsr_next(m_lfsr);
  end

  // Expected set given the LFSR value current at the accepting edge
  task automatic model_set(input logic [31:0] l0, input logic [7:0] rt, input int w,
                           output logic [63:0] x, output logic [63:0] d, output logic [63:0] s);
    logic [31:0] l;
    l = l0;
    x = '0; d = '0; s = '0;
    for (int i = 0; i < w; i++) begin
      l = lfsr_next(l);
      x[i] = l[0];
      d[i] = (int'(l[15:8]) < int'(rt));
      s[i] = (int'(l[23:16]) < int'(rt));
    end
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit big, input logic rq, input logic [7:0] rt, input logic ak);
    if (big) begin req32 = rq; rate32 = rt; ack32 = ak; end
    else     begin req8  = rq; rate8  = rt; ack8  = ak; end
  endtask

  function automatic logic get_busy(input bit big);  return big ? busy32 : busy8;   endfunction
  function automatic logic get_valid(input bit big); return big ? valid32 : valid8; endfunction
  function automatic logic [63:0] get_x(input bit big); return big ? 64'(xm32) : 64'(xm8); endfunction
  function automatic logic [63:0] get_d(input bit big); return big ? 64'(dm32) : 64'(dm8); endfunction
  function automatic logic [63:0] get_s(input bit big); return big ? 64'(sm32) : 64'(sm8); endfunction

  task automatic reset_seq();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // Issue one req, count BUILD cycles, then compare the held set against the model
  task automatic run_set(input bit big, input logic [7:0] rt, input bit noisy,
                         output logic [63:0] ex, output logic [63:0] ed, output logic [63:0] es);
    int w, n;
    w = big ? 32 : 8;
    @(negedge clk);
    drive(big, 1'b1, rt, 1'b0);
    model_set(m_lfsr, rt, w, ex, ed, es);
    @(negedge clk);
    drive(big, 1'b0, rt, 1'b0);
    n = 0;
    while (get_busy(big) && n < 100) begin
      n++;
      if (noisy) drive(big, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      @(negedge clk);
    end
    drive(big, 1'b0, rt, 1'b0);
    check_val($sformatf("busy_cycles_w%0d", w), 64'(n), 64'(w));
    check_val($sformatf("valid_w%0d", w), 64'(get_valid(big)), 64'd1);
    check_val($sformatf("xmask_w%0d_r%0d", w, rt), get_x(big), ex);
    check_val($sformatf("dmask_w%0d_r%0d", w, rt), get_d(big), ed);
    check_val($sformatf("smask_w%0d_r%0d", w, rt), get_s(big), es);
  endtask

  task automatic do_ack(input bit big);
    drive(big, 1'b0, 8'h00, 1'b1);
    @(negedge clk);
    check_val("ack_to_idle", {62'd0, get_valid(big), get_busy(big)}, 64'd0);
    drive(big, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ex, ed, es, gx, gd, gs, x1;
    bit big, ok;

    reset_seq();
    check_val("rst_flags", {60'd0, busy8, valid8, busy32, valid32}, 64'd0);
    check_val("rst_mask8", {40'd0, xm8, dm8, sm8}, 64'd0);
    check_val("rst_mask32", {32'd0, xm32 | dm32 | sm32}, 64'd0);

    // Golden first set after reset on the Width=8 instance
    run_set(1'b0, 8'h40, 1'b0, gx, gd, gs);

    // Held set must ignore req/rate noise until ack, then stay put in IDLE
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      @(negedge clk);
      if (!valid8 || busy8 || 64'(xm8) != gx || 64'(dm8) != gd || 64'(sm8) != gs) ok = 1'b0;
    end
    check_val("hold_stable", 64'(ok), 64'd1);
    do_ack(1'b0);
    @(negedge clk);
    check_val("idle_retain", {40'd0, xm8, dm8, sm8}, {40'd0, gx[7:0], gd[7:0], gs[7:0]});

    // rate=0: no mutation at all
    run_set(1'b1, 8'h00, 1'b1, ex, ed, es);
    check_val("rate0_zero", {dm32, sm32}, 64'd0);
    do_ack(1'b1);

    // rate=255: two back-to-back sets must differ
    run_set(1'b1, 8'hFF, 1'b0, ex, ed, es);
    x1 = {dm32, xm32};
    do_ack(1'b1);
    run_set(1'b1, 8'hFF, 1'b0, ex, ed, es);
    check_val("rate255_differ", 64'(x1 != {dm32, xm32}), 64'd1);
    do_ack(1'b1);

    // Random sets on both widths
    for (int t = 0; t < 8; t++) begin
      big = 1'($urandom_range(0, 1));
      run_set(big, 8'($urandom), 1'b1, ex, ed, es);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_ack(big);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // req together with ack in HOLD: back to IDLE, req not taken
    run_set(1'b0, 8'h80, 1'b0, ex, ed, es);
    drive(1'b0, 1'b1, 8'h80, 1'b1);
    @(negedge clk);
    check_val("reqack_idle", {62'd0, valid8, busy8}, 64'd0);
    drive(1'b0, 1'b0, 8'h80, 1'b0);
    @(negedge clk);
    check_val("reqack_noaccept", 64'(busy8), 64'd0);
    check_val("reqack_keep", 64'(xm8), ex);

    // Reset with the counter at 3 mid-BUILD
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h40, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'h40, 1'b0);
    repeat (3) @(negedge clk);
    check_val("pre_rst_busy", 64'(busy8), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("midrst_flags", {60'd0, busy8, valid8, busy32, valid32}, 64'd0);
    check_val("midrst_masks", {40'd0, xm8, dm8, sm8}, 64'd0);
    reset_seq();
    run_set(1'b0, 8'h40, 1'b0, ex, ed, es);
    check_val("golden_x", 64'(xm8), gx);
    check_val("golden_d", 64'(dm8), gd);
    check_val("golden_s", 64'(sm8), gs);
    do_ack(1'b0);

`ifdef GA_MASK_SEED_LOAD_EN
    @(negedge clk);
    seed = 32'h0; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    check_val("seed0_lfsr", 64'(u_dut8.r_lfsr), 64'(SEED));
    seed = 32'h1; seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    run_set(1'b1, 8'h80, 1'b0, ex, ed, es);
    do_ack(1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ga_mask_generator.md
GA_MASK_GENERATOR -- requirements
Module: ga_mask_generator

Interface
REQ-001 SHALL have parameter Width, default 32, meaning chromosome width in bits (legal range 2..64).
REQ-002 SHALL have parameter Seed, default 32'hACE12468, meaning LFSR reset value (nonzero).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  request one new mask set; sampled only in IDLE.
REQ-006 SHALL have port rate  input  8  mutation threshold; sampled on req acceptance.
REQ-007 SHALL have port ack  input  1  consumer has taken the current mask set.
REQ-008 SHALL have port busy  output  1  high while in BUILD.
REQ-009 SHALL have port valid  output  1  mask set stable and available.
REQ-010 SHALL have port crossover_mask  output  Width  1 = bit from dad into daughter, from mom into son.
REQ-011 SHALL have port daughter_mutation_mask  output  Width  XOR mask for daughter.
REQ-012 SHALL have port son_mutation_mask  output  Width  XOR mask for son.

Function
REQ-013 SHALL contain a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (shift right, XOR 32'h80200003 when bit0=1), advancing every cycle in every state.
REQ-014 SHALL implement FSM states IDLE, BUILD, HOLD; IDLE->BUILD on req, BUILD->HOLD after the bit counter reaches Width-1, HOLD->IDLE on ack.
REQ-015 SHALL, on req acceptance, capture rate, clear bit counter to 0, and clear all three mask registers.
REQ-016 SHALL, on each BUILD cycle with counter i, write crossover_mask[i]=lfsr[0], daughter_mutation_mask[i]=(lfsr[15:8]<rate), son_mutation_mask[i]=(lfsr[23:16]<rate), using the current (pre-advance) LFSR value, then increment i.
REQ-017 SHALL use unsigned comparison; rate=0 yields all-zero mutation masks; rate=255 sets a bit unless the byte equals 8'hFF.
REQ-018 SHALL assert valid exactly in HOLD; with req high at edge t, busy is high for Width cycles and valid rises at edge t+Width+1.
REQ-019 SHALL hold all mask outputs constant while valid is high, regardless of req or rate.
REQ-020 SHALL ignore req in BUILD and HOLD (no queuing); req and ack both high in HOLD returns to IDLE only, req not accepted that cycle.
REQ-021 SHALL ignore ack outside HOLD.
REQ-022 SHALL keep mask outputs unchanged in IDLE after a completed set until the next accepted req.

Reset
REQ-023 SHALL on rst_n low, immediately: state IDLE, busy=0, valid=0, all masks zero, counter zero, LFSR=Seed.
REQ-024 SHALL abandon any BUILD or HOLD in progress on reset, with no partial set ever flagged valid.

Configuration
REQ-025 SHALL, with GA_MASK_SEED_LOAD_EN defined, add ports seed_load (input 1) and seed (input 32); seed_load high loads LFSR with seed next edge (Seed if seed==0), overriding the advance, in any state; a BUILD in progress continues using the new sequence.
REQ-026 SHALL, without GA_MASK_SEED_LOAD_EN, have neither port, and the LFSR is reseeded only by reset.

Verification
REQ-027 Width=8, req one cycle at edge 5 after reset release -> busy high edges 6..13, valid high from edge 14 until ack.
REQ-028 rate=0, any req -> daughter and son mutation masks 0; crossover_mask equals reference-model LFSR bit0 sequence.
REQ-029 rate=255, Width=32 -> mutation masks match model (bytes != FF set); two consecutive sets differ.
REQ-030 valid high, ack held low 20 cycles with req toggling, rate changed -> masks, valid unchanged; ack -> IDLE next edge.
REQ-031 rst_n low mid-BUILD (counter=3) -> all outputs 0 immediately; after release LFSR restarts at Seed and first set equals post-reset golden set.
REQ-032 GA_MASK_SEED_LOAD_EN, seed_load with seed=0 -> LFSR equals 32'hACE12468 next edge; seed=32'h1 -> model-matched masks.
